// File: rtl/huffman_pkg.sv
// Shared types and constants for the 4-symbol Huffman code generator.
// Symbols A..D map to leaf-mask bits 0..3 and to nibble/field 0..3 of the
// packed CODE/LEN outputs.
package huffman_pkg;

    localparam int NUM_SYM   = 4;
    localparam int ENTRY_W   = 8;
    localparam int TAG_W     = 4;
    localparam int COUNT_W   = 4;
    localparam int WEIGHT_W  = 6;
    localparam int CODE_W    = 4;
    localparam int LEN_W     = 2;

    // Three merges reduce four leaves to one root; the counter runs 0..2
    localparam int MERGE_COUNT = NUM_SYM - 1;

    localparam logic [TAG_W-1:0] TAG_A = 4'hA;
    localparam logic [TAG_W-1:0] TAG_B = 4'hB;
    localparam logic [TAG_W-1:0] TAG_C = 4'hC;
    localparam logic [TAG_W-1:0] TAG_D = 4'hD;

    typedef struct packed {
        logic [WEIGHT_W-1:0] weight;
        logic [NUM_SYM-1:0]  mask;
    } node_t;

    // Filler for list slots that no longer hold a live node; its weight
    // exceeds any reachable sum (max 60) so insertion always lands before it
    localparam node_t EMPTY_NODE = {{WEIGHT_W{1'b1}}, {NUM_SYM{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MERGE,
        FINISH
    } state_t;

    // One-hot leaf mask for a tag; unknown tags give an empty mask
    function automatic logic [NUM_SYM-1:0] tag_to_mask(input logic [TAG_W-1:0] tag);
        logic [NUM_SYM-1:0] m;
        case (tag)
            TAG_A:   m = 4'b0001;
            TAG_B:   m = 4'b0010;
            TAG_C:   m = 4'b0100;
            TAG_D:   m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/huff_node_insert.sv
// Stable insertion of one node into a 3-entry weight-sorted list. The new
// node goes after every entry whose weight is less than or equal to its own.
module huff_node_insert
    import huffman_pkg::*;
(
    input  node_t list_in  [NUM_SYM-1],
    input  node_t node_in,
    output node_t list_out [NUM_SYM]
);

    logic [NUM_SYM-2:0] le;

    // Entries at or below the new weight form a prefix; shift the rest up by one
    always_comb begin
        for (int i = 0; i < NUM_SYM - 1; i++) begin
            le[i] = (list_in[i].weight <= node_in.weight);
        end
        list_out[0] = le[0] ? list_in[0] : node_in;
        list_out[1] = le[1] ? list_in[1] : (le[0] ? node_in : list_in[0]);
        list_out[2] = le[2] ? list_in[2] : (le[1] ? node_in : list_in[1]);
        list_out[3] = le[2] ? node_in : list_in[2];
    end

endmodule

// File: rtl/huffman_code_gen.sv
// Huffman code generator for four symbols A..D. A sorted weight list is
// latched on start, merged three times (two lightest nodes per cycle), and
// the resulting codes/lengths are published with a one-cycle done pulse.
// Optional feature: define HUFF_INPUT_CHECK_EN to validate tags and ordering
// during LOAD and report rejected input through err.
module huffman_code_gen
    import huffman_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_SYM*ENTRY_W-1:0]  sort_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_SYM*CODE_W-1:0]   code_out,
    output logic [NUM_SYM*LEN_W-1:0]    len_out,
    output logic                        err
);

    state_t                       state;
    logic [NUM_SYM*ENTRY_W-1:0]   sort_reg;
    node_t                        list      [NUM_SYM];
    logic [CODE_W-1:0]            code_work [NUM_SYM];
    logic [LEN_W-1:0]             len_work  [NUM_SYM];
    logic [1:0]                   merge_cnt;

    node_t                        load_list   [NUM_SYM];
    node_t                        rest        [NUM_SYM-1];
    node_t                        merged_node;
    node_t                        merged_list [NUM_SYM];
    logic [CODE_W-1:0]            code_nxt    [NUM_SYM];
    logic [LEN_W-1:0]             len_nxt     [NUM_SYM];
    logic [NUM_SYM*CODE_W-1:0]    code_pack;
    logic [NUM_SYM*LEN_W-1:0]     len_pack;

    // Decode the latched entries into leaf nodes with zero-extended weights
    always_comb begin
        for (int i = 0; i < NUM_SYM; i++) begin
            load_list[i].weight = {{(WEIGHT_W-COUNT_W){1'b0}},
                                   sort_reg[i*ENTRY_W+TAG_W +: COUNT_W]};
            load_list[i].mask   = tag_to_mask(sort_reg[i*ENTRY_W +: TAG_W]);
        end
    end

    // One merge step: combine the two lightest nodes and extend leaf codes
    always_comb begin
        merged_node.weight = list[0].weight + list[1].weight;
        merged_node.mask   = list[0].mask | list[1].mask;
        rest[0] = list[2];
        rest[1] = list[3];
        rest[2] = EMPTY_NODE;
        code_pack = '0;
        len_pack  = '0;
        for (int s = 0; s < NUM_SYM; s++) begin
            code_nxt[s] = code_work[s];
            len_nxt[s]  = len_work[s];
            if (list[0].mask[s]) begin
                code_nxt[s][len_work[s]] = 1'b0;
                len_nxt[s] = len_work[s] + LEN_W'(1);
            end else if (list[1].mask[s]) begin
                code_nxt[s][len_work[s]] = 1'b1;
                len_nxt[s] = len_work[s] + LEN_W'(1);
            end
            code_pack[s*CODE_W +: CODE_W] = code_nxt[s];
            len_pack[s*LEN_W +: LEN_W]    = len_nxt[s];
        end
    end

    huff_node_insert u_insert (
        .list_in  (rest),
        .node_in  (merged_node),
        .list_out (merged_list)
    );

`ifdef HUFF_INPUT_CHECK_EN
    logic input_ok;
    logic err_reg;

    // Accept only a full A..D tag set (OR of one-hot masks) in non-decreasing weight order
    always_comb begin
        input_ok = ((load_list[0].mask | load_list[1].mask |
                     load_list[2].mask | load_list[3].mask) == {NUM_SYM{1'b1}});
        for (int i = 0; i < NUM_SYM - 1; i++) begin
            if (load_list[i].weight > load_list[i+1].weight) begin
                input_ok = 1'b0;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Control FSM with registered outputs; results publish on entry to FINISH
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            code_out  <= '0;
            len_out   <= '0;
            sort_reg  <= '0;
            merge_cnt <= '0;
            for (int i = 0; i < NUM_SYM; i++) begin
                list[i]      <= EMPTY_NODE;
                code_work[i] <= '0;
                len_work[i]  <= '0;
            end
`ifdef HUFF_INPUT_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sort_reg <= sort_in;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    merge_cnt <= '0;
                    for (int i = 0; i < NUM_SYM; i++) begin
                        list[i]      <= load_list[i];
                        code_work[i] <= '0;
                        len_work[i]  <= '0;
                    end
`ifdef HUFF_INPUT_CHECK_EN
                    if (!input_ok) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err_reg  <= 1'b1;
                        code_out <= '0;
                        len_out  <= '0;
                    end else begin
                        state    <= MERGE;
                    end
`else
                    state <= MERGE;
`endif
                end
                MERGE: begin
                    merge_cnt <= merge_cnt + 2'd1;
                    for (int i = 0; i < NUM_SYM; i++) begin
                        list[i]      <= merged_list[i];
                        code_work[i] <= code_nxt[i];
                        len_work[i]  <= len_nxt[i];
                    end
                    if (merge_cnt == 2'(MERGE_COUNT - 1)) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        code_out <= code_pack;
                        len_out  <= len_pack;
`ifdef HUFF_INPUT_CHECK_EN
                        err_reg  <= 1'b0;
`endif
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_code_gen.sv
// Self-checking bench for huffman_code_gen. A queue-based Huffman model
// predicts codes, lengths, error flag and latency for directed and random
// sorted weight lists; timing, busy/done behaviour and reset are checked too.
module tb_huffman_code_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] sort_in;
    logic        busy;
    logic        done;
    logic [15:0] code_out;
    logic [7:0]  len_out;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef HUFF_INPUT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct {
        int         w;
        logic [3:0] m;
    } mnode_t;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    huffman_code_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sort_in  (sort_in),
        .busy     (busy),
        .done     (done),
        .code_out (code_out),
        .len_out  (len_out),
        .err      (err)
    );

    // Count a comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: repeatedly pop the two lightest nodes from a queue, prepend
    // a bit to every member leaf, and reinsert the sum after equal weights
    function automatic void refModel(input logic [31:0] s, output logic [15:0] code,
                                     output logic [7:0] len, output logic e);
        mnode_t     q[$];
        mnode_t     a, b, n;
        int         w[4];
        int         sym[4];
        int         codes[4];
        int         lens[4];
        bit         seen[4];
        int         pos;
        logic [3:0] t;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i]     = int'(s[i*8+4 +: 4]);
            t        = s[i*8 +: 4];
            sym[i]   = (t >= 4'hA && t <= 4'hD) ? int'(t) - 10 : -1;
            codes[i] = 0;
            lens[i]  = 0;
            seen[i]  = 1'b0;
        end
        if (CHECK_EN) begin
            for (int i = 0; i < 4; i++) begin
                if (sym[i] < 0) e = 1'b1;
                else if (seen[sym[i]]) e = 1'b1;
                else seen[sym[i]] = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (w[i] > w[i+1]) e = 1'b1;
            end
        end
        code = '0;
        len  = '0;
        if (e) return;
        for (int i = 0; i < 4; i++) begin
            n.w = w[i];
            n.m = (sym[i] >= 0) ? 4'(1 << sym[i]) : 4'b0000;
            q.push_back(n);
        end
        for (int step = 0; step < 3; step++) begin
            a = q.pop_front();
            b = q.pop_front();
            for (int k = 0; k < 4; k++) begin
                if (a.m[k]) begin
                    lens[k]++;
                end else if (b.m[k]) begin
                    codes[k] += (1 << lens[k]);
                    lens[k]++;
                end
            end
            n.w = a.w + b.w;
            n.m = a.m | b.m;
            pos = q.size();
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].w > n.w) begin
                    pos = i;
                    break;
                end
            end
            q.insert(pos, n);
        end
        for (int k = 0; k < 4; k++) begin
            code[k*4 +: 4] = 4'(codes[k]);
            len[k*2 +: 2]  = 2'(lens[k]);
        end
    endfunction

    // Run one job; poke bit k re-asserts start (with altered data) in cycle k
    task automatic applyStimulus(input logic [31:0] s, input logic [15:0] poke,
                                 input string name);
        logic [15:0] ec;
        logic [7:0]  el;
        logic        ee;
        int          lat;
        int          first_done;
        int          ndone;
        int          busy_bad;
        refModel(s, ec, el, ee);
        lat = ee ? 2 : 5;
        first_done = 0;
        ndone = 0;
        busy_bad = 0;
        @(negedge clk);
        sort_in = s;
        start   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (busy !== (k < lat)) busy_bad++;
            start   = poke[k];
            sort_in = poke[k] ? ~s : s;
        end
        start = 1'b0;
        checkOutput({name, " latency"}, first_done, lat);
        checkOutput({name, " done_count"}, ndone, 1);
        checkOutput({name, " busy_profile"}, busy_bad, 0);
        checkOutput({name, " code"}, code_out, ec);
        checkOutput({name, " len"}, len_out, el);
        checkOutput({name, " err"}, err, ee);
    endtask

    // Directed scenarios followed by randomized sorted weight lists
    initial begin
        logic [3:0]  cnt[4];
        logic [3:0]  tags[4];
        logic [3:0]  tmp;
        logic [31:0] s;
        int          j;
        int          ndone;

        rst = 1'b1;
        start = 1'b0;
        sort_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset code", code_out, 16'h0000);
        checkOutput("reset len", len_out, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(32'h4D3C2B1A, 16'h0000, "ascending");
        checkOutput("ascending code const", code_out, 16'h0276);
        checkOutput("ascending len const", len_out, 8'h6F);

        applyStimulus(32'h1D1C1B1A, 16'h0000, "all_one");
        checkOutput("all_one code const", code_out, 16'h3210);
        checkOutput("all_one len const", len_out, 8'hAA);

        applyStimulus(32'h0D0C0B0A, 16'h0000, "all_zero");
        checkOutput("all_zero code const", code_out, 16'h3210);
        checkOutput("all_zero len const", len_out, 8'hAA);

        applyStimulus(32'hFDFCFBFA, 16'h0000, "all_max");

        // start re-pulsed in cycles 2, 3 and during the done cycle
        applyStimulus(32'h4D3C2B1A, 16'h002C, "restart_ignored");
        checkOutput("restart code const", code_out, 16'h0276);

        // reset in cycle 3 of a run aborts it and clears outputs
        @(negedge clk);
        sort_in = 32'h1D1C1B1A;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_reset busy", busy, 0);
        checkOutput("midrun_reset code", code_out, 16'h0000);
        checkOutput("midrun_reset len", len_out, 8'h00);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checkOutput("midrun_reset no_done", ndone, 0);
        applyStimulus(32'h4D3C2B1A, 16'h0000, "after_reset");

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        sort_in = 32'h4D3C2B1A;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("reset_vs_start busy", busy, 0);
        checkOutput("reset_vs_start code", code_out, 16'h0000);
        repeat (6) @(negedge clk);

`ifdef HUFF_INPUT_CHECK_EN
        applyStimulus(32'h1A2B3C4D, 16'h0000, "descending");
        checkOutput("descending err const", err, 1);
        applyStimulus(32'h4D3C2B2B, 16'h0000, "dup_tag");
        checkOutput("dup_tag err const", err, 1);
        checkOutput("dup_tag code const", code_out, 16'h0000);
`endif

        for (int iter = 0; iter < 30; iter++) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]  = 4'($urandom_range(15));
                tags[i] = 4'hA + 4'(i);
            end
            for (int a = 0; a < 3; a++) begin
                for (int b = 0; b < 3 - a; b++) begin
                    if (cnt[b] > cnt[b+1]) begin
                        tmp = cnt[b];
                        cnt[b] = cnt[b+1];
                        cnt[b+1] = tmp;
                    end
                end
            end
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(i);
                tmp = tags[i];
                tags[i] = tags[j];
                tags[j] = tmp;
            end
            if (CHECK_EN && $urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) begin
                    tags[2] = tags[1];
                end else begin
                    cnt[0] = 4'hF;
                    cnt[3] = 4'h0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                s[i*8 +: 8] = {cnt[i], tags[i]};
            end
            applyStimulus(s, 16'h0000, $sformatf("random%0d", iter));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
